// File: rtl/bcd_display_driver.sv
// Binary to multi-digit 7-segment driver, active-low segments.
// Decimal via sequential double-dabble, hex via direct nibble split.
module bcd_display_driver #(
   parameter int WIDTH = 16,
   parameter int NDIG  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    din,
   input  logic                mode_hex,
   input  logic                blank_lz,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [7*NDIG-1:0]   HEX
);

   localparam int BW   = 4 * NDIG;
   localparam int PW   = (WIDTH > BW) ? WIDTH : BW;
   localparam int CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } state_t;

   state_t            state;
   state_t            nxt;
   logic [WIDTH-1:0]  bin;
   logic [BW-1:0]     bcd;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     bcd_nx;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic              hexm;
   logic              blz;
   logic              ovf_s;
   logic [PW-1:0]     pad;
   logic              hovf;
   logic              ovf_d;
   logic [7*NDIG-1:0] disp;
   logic [3:0]        nib;
   logic              lead;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'ha: g = 7'b0001000;
         4'hb: g = 7'b1100000;
         4'hc: g = 7'b0110001;
         4'hd: g = 7'b1000010;
         4'he: g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = mode_hex ? LOAD : CONV;
         CONV: if (cnt == LAST) nxt = LOAD;
         LOAD: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // One double-dabble step: correct nibbles, then shift {bcd, bin}
   always_comb begin
      adj = bcd;
      for (int k = 0; k < NDIG; k++) begin
         if (bcd[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      carry  = adj[BW-1];
      bcd_nx = {adj[BW-2:0], bin[WIDTH-1]};
   end

   always_comb begin
      pad  = PW'(bin);
      hovf = 1'b0;
      for (int i = BW; i < PW; i++) hovf = hovf | pad[i];
   end

   // Walk digits from the top so leading zeros are known as we go
   always_comb begin
      ovf_d = hexm ? hovf : ovf_s;
      disp  = '1;
      nib   = '0;
      lead  = 1'b1;
      for (int k = NDIG - 1; k >= 0; k--) begin
         nib = hexm ? pad[4*k +: 4] : bcd[4*k +: 4];
         if (nib != 4'd0) lead = 1'b0;
         if (ovf_d)
            disp[7*k +: 7] = 7'b1111110;
         else if (blz && lead && (k != 0))
            disp[7*k +: 7] = 7'b1111111;
         else
            disp[7*k +: 7] = glyph(nib);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         hexm     <= 1'b0;
         blz      <= 1'b0;
         ovf_s    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         HEX      <= '1;
      end else begin
         done <= 1'b0;
         busy <= (nxt != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  bin   <= din;
                  hexm  <= mode_hex;
                  blz   <= blank_lz;
                  bcd   <= '0;
                  cnt   <= '0;
                  ovf_s <= 1'b0;
               end
            end
            CONV: begin
               bin <= bin << 1;
               bcd <= bcd_nx;
               cnt <= cnt + 1'b1;
               if (carry) ovf_s <= 1'b1;
            end
            LOAD: begin
               HEX      <= disp;
               overflow <= ovf_d;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: 5-digit and 4-digit instances
// driven in parallel, checked against an arithmetic digit model.
module tb_bcd_display_driver;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] din;
   logic        mode_hex;
   logic        blank_lz;
   logic        busy5, done5, ovf5;
   logic [34:0] hex5;
   logic        busy4, done4, ovf4;
   logic [27:0] hex4;

   int ncmp = 0;
   int nfail = 0;

   logic [6:0] gl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   bcd_display_driver #(.WIDTH(16), .NDIG(5)) dut5 (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .mode_hex(mode_hex), .blank_lz(blank_lz),
      .busy(busy5), .done(done5), .overflow(ovf5), .HEX(hex5)
   );

   bcd_display_driver #(.WIDTH(16), .NDIG(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .mode_hex(mode_hex), .blank_lz(blank_lz),
      .busy(busy4), .done(done4), .overflow(ovf4), .HEX(hex4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic void model(input int nd, input logic [15:0] v,
                                 input bit hx, input bit blz,
                                 output logic [34:0] h, output bit ov);
      int     base;
      longint p;
      int     d [5];
      int     msd;
      base = hx ? 16 : 10;
      p    = 1;
      msd  = -1;
      h    = '0;
      for (int k = 0; k < nd; k++) begin
         d[k] = int'((longint'(v) / p) % base);
         p    = p * base;
         if (d[k] != 0) msd = k;
      end
      ov = (longint'(v) >= p);
      for (int k = 0; k < nd; k++) begin
         if (ov)
            h[7*k +: 7] = 7'b1111110;
         else if (blz && k > msd && k > 0)
            h[7*k +: 7] = 7'b1111111;
         else
            h[7*k +: 7] = gl[d[k]];
      end
   endfunction

   task automatic req(input logic [15:0] v, input bit hx, input bit blz,
                      input int intr, input logic [15:0] v2);
      logic [34:0] e5, e4;
      bit          o5, o4;
      int          f5, f4, n5, n4;
      logic [34:0] h5;
      logic [27:0] h4;
      logic        c5, c4;
      int          lat;
      model(5, v, hx, blz, e5, o5);
      model(4, v, hx, blz, e4, o4);
      lat = hx ? 1 : 17;
      f5 = -1; f4 = -1; n5 = 0; n4 = 0;
      h5 = '0; h4 = '0; c5 = 1'bx; c4 = 1'bx;
      @(negedge clk);
      din = v; mode_hex = hx; blank_lz = blz; start = 1'b1;
      @(negedge clk);
      start = 1'b0; din = ~v; mode_hex = ~hx; blank_lz = ~blz;
      chk("busy_acc", {busy5, busy4}, 2'b11);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (done5) begin
            n5++;
            if (f5 < 0) f5 = c;
            h5 = hex5; c5 = ovf5;
         end
         if (done4) begin
            n4++;
            if (f4 < 0) f4 = c;
            h4 = hex4; c4 = ovf4;
         end
         start = (c == intr);
         if (c == intr) din = v2;
      end
      start = 1'b0;
      chk("lat5", 64'(f5), 64'(lat));
      chk("lat4", 64'(f4), 64'(lat));
      chk("ndone5", 64'(n5), 64'd1);
      chk("ndone4", 64'(n4), 64'd1);
      chk("hex5", 64'(h5), 64'(e5));
      chk("ovf5", 64'(c5), 64'(o5));
      chk("hex4", 64'(h4), 64'(e4[27:0]));
      chk("ovf4", 64'(c4), 64'(o4));
      chk("hold5", 64'(hex5), 64'(e5));
      chk("hold4", 64'(hex4), 64'(e4[27:0]));
      chk("busy_end", {busy5, busy4}, 2'b00);
   endtask

   initial begin
      int dn;
      logic [15:0] rv;
      bit rh, rb;
      rst = 1'b1; start = 1'b0; din = '0;
      mode_hex = 1'b0; blank_lz = 1'b0;
      #1;
      chk("rst_hex5", 64'(hex5), 64'h7_ffff_ffff);
      chk("rst_hex4", 64'(hex4), 64'h0fff_ffff);
      chk("rst_flags", {busy5, done5, ovf5, busy4, done4, ovf4}, 6'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      req(16'd12345, 1'b0, 1'b0, -1, 16'd0);
      chk("lit12345", 64'(hex5),
          64'({7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100}));
      req(16'd40, 1'b0, 1'b1, -1, 16'd0);
      req(16'd0, 1'b0, 1'b1, -1, 16'd0);
      req(16'd0, 1'b0, 1'b0, -1, 16'd0);
      req(16'd1002, 1'b0, 1'b1, -1, 16'd0);
      req(16'hBEEF, 1'b1, 1'b0, -1, 16'd0);
      chk("litbeef", 64'(hex5),
          64'({7'b0000001, 7'b1100000, 7'b0110000,
               7'b0110000, 7'b0111000}));
      req(16'hBEEF, 1'b1, 1'b1, -1, 16'd0);
      req(16'd10000, 1'b0, 1'b0, -1, 16'd0);
      chk("ovf10000", 64'(hex4), 64'h0fdf_bf7e);
      req(16'd9999, 1'b0, 1'b0, -1, 16'd0);
      req(16'd65535, 1'b0, 1'b1, -1, 16'd0);
      req(16'h00A0, 1'b1, 1'b1, -1, 16'd0);
      req(16'd12345, 1'b0, 1'b0, 3, 16'd54321);

      // abort a conversion with an asynchronous reset
      @(negedge clk);
      din = 16'd777; mode_hex = 1'b0; blank_lz = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_hex5", 64'(hex5), 64'h7_ffff_ffff);
      chk("mid_hex4", 64'(hex4), 64'h0fff_ffff);
      chk("mid_flags", {busy5, done5, ovf5, busy4, done4, ovf4}, 6'b0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done5 || done4 || busy5 || busy4) dn++;
      end
      chk("no_done_after_abort", 64'(dn), 64'd0);
      req(16'd321, 1'b0, 1'b1, -1, 16'd0);

      for (int i = 0; i < 30; i++) begin
         rv = 16'($urandom);
         if (i % 3 == 0) rv = 16'($urandom_range(0, 200));
         if (i % 5 == 0) rv = 16'($urandom_range(9990, 10010));
         rh = 1'($urandom);
         rb = 1'($urandom);
         req(rv, rh, rb, -1, 16'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
